// File: rtl/system_buffer_reader_pkg.sv
// Shared defines and package for the system buffer read side.
// Macros:
//   SYSTEM_BUFFER_ADDR_WIDTH : buffer address width in 32-bit words
//   SYSTEM_BUFFER_PTR_WIDTH  : pointer width (address width plus wrap bit)
// Package items:
//   SB_ADDR_WIDTH, SB_DATA_WIDTH, SB_FIFO_DEPTH default sizes
//   count_width()            : bits needed to hold 0..depth

`ifndef SYSTEM_BUFFER_DEFINES
`define SYSTEM_BUFFER_DEFINES
`define SYSTEM_BUFFER_ADDR_WIDTH 10
`define SYSTEM_BUFFER_PTR_WIDTH (`SYSTEM_BUFFER_ADDR_WIDTH + 1)
`endif

package system_buffer_reader_pkg;

    localparam int SB_ADDR_WIDTH = `SYSTEM_BUFFER_ADDR_WIDTH;
    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_FIFO_DEPTH = 2;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/system_buffer_skid_fifo.sv
// Small skid FIFO that captures port-B read returns for the parser stream.
// Ports:
//   i_clock     : clock
//   i_resetn    : asynchronous active-low reset
//   i_clear     : synchronous clear (stream flush), wins over push/pop
//   i_push      : write i_push_data at the tail
//   i_push_data : data to store
//   i_pop       : drop the head entry
//   o_head_data : oldest stored entry
//   o_count     : number of stored entries

module system_buffer_skid_fifo
    import system_buffer_reader_pkg::*;
#(
    parameter int DEPTH = SB_FIFO_DEPTH,
    parameter int WIDTH = SB_DATA_WIDTH
) (
    input  logic                          i_clock,
    input  logic                          i_resetn,
    input  logic                          i_clear,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_push_data,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_head_data,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int CW = count_width(DEPTH);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [IW-1:0]    r_wr_idx;
    logic [IW-1:0]    r_rd_idx;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    // Guards keep the structure consistent even if a caller misbehaves.
    assign w_push = i_push & (r_count != CW'(DEPTH));
    assign w_pop  = i_pop & (r_count != '0);

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= i_push_data;
                r_wr_idx        <= next_idx(r_wr_idx);
            end
            if (w_pop) begin
                r_rd_idx <= next_idx(r_rd_idx);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = r_mem[r_rd_idx];
    assign o_count     = r_count;

endmodule

// File: rtl/system_buffer_reader.sv
// Read-side controller for the dual-port system buffer. Follows the writer's
// pointer, issues 1-cycle-latency port-B reads, captures returns in a skid
// FIFO and presents them to the bitstream parser as a valid/ready stream.
// Ports:
//   clock, resetn     : clock / asynchronous active-low reset
//   Write_Pointer_I   : synchronized writer pointer (MSB = wrap bit)
//   Flush_I           : restart the stream at the current writer pointer
//   Enable_B_O        : port-B read enable
//   Address_B_O       : port-B word address
//   Data_B_I          : port-B read data, one cycle after Enable_B_O
//   Word_O            : word to parser (0 when not valid)
//   Word_Valid_O      : Word_O valid
//   Word_Ready_I      : parser accepts Word_O
//   Read_Pointer_O    : read pointer returned to the writer side
//   Level_O           : words written but not yet issued for read
//   Empty_O           : Level_O == 0
//   Overrun_O         : sticky, writer ran more than a full buffer ahead

module system_buffer_reader
    import system_buffer_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int FIFO_DEPTH = SB_FIFO_DEPTH
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [ADDR_WIDTH:0]   Write_Pointer_I,
    input  logic                  Flush_I,
    output logic                  Enable_B_O,
    output logic [ADDR_WIDTH-1:0] Address_B_O,
    input  logic [31:0]           Data_B_I,
    output logic [31:0]           Word_O,
    output logic                  Word_Valid_O,
    input  logic                  Word_Ready_I,
    output logic [ADDR_WIDTH:0]   Read_Pointer_O,
    output logic [ADDR_WIDTH:0]   Level_O,
    output logic                  Empty_O,
    output logic                  Overrun_O
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam int CW = count_width(FIFO_DEPTH);
    localparam logic [PW-1:0] OVERRUN_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0] r_rd_ptr;
    logic          r_inflight;
    logic          r_overrun;

    logic [PW-1:0] w_level;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [31:0]   w_head;
    logic          w_valid;
    logic          w_pop;
    logic [CW:0]   w_used;
    logic [CW:0]   w_limit;
    logic          w_issue;

    assign w_level = Write_Pointer_I - r_rd_ptr;
    assign w_empty = (r_rd_ptr == Write_Pointer_I);
    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid & Word_Ready_I;

    // occupancy + inflight - pop < depth, rearranged to avoid underflow.
    assign w_used  = (CW+1)'(w_count) + (CW+1)'(r_inflight);
    assign w_limit = (CW+1)'(FIFO_DEPTH) + (CW+1)'(w_pop);
    assign w_issue = !w_empty & !Flush_I & (w_used < w_limit);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else if (Flush_I) begin
            r_rd_ptr   <= Write_Pointer_I;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_overrun <= 1'b0;
        end else if (w_level > OVERRUN_LIMIT) begin
            r_overrun <= 1'b1;
        end
    end

    // A flush drops the in-flight return and everything already captured.
    system_buffer_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_skid_fifo (
        .i_clock     (clock),
        .i_resetn    (resetn),
        .i_clear     (Flush_I),
        .i_push      (r_inflight & !Flush_I),
        .i_push_data (Data_B_I),
        .i_pop       (w_pop & !Flush_I),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign Enable_B_O     = w_issue;
    assign Address_B_O    = r_rd_ptr[ADDR_WIDTH-1:0];
    assign Word_Valid_O   = w_valid;
    assign Word_O         = w_valid ? w_head : 32'h0;
    assign Read_Pointer_O = r_rd_ptr;
    assign Level_O        = w_level;
    assign Empty_O        = w_empty;
    assign Overrun_O      = r_overrun;

endmodule

// File: tb/tb_system_buffer_reader.sv
module tb_system_buffer_reader;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [10:0] wp = '0;
    logic        flush = 1'b0;
    logic        en;
    logic [9:0]  addr;
    logic [31:0] data_b = '0;
    logic [31:0] word;
    logic        wvalid;
    logic        ready = 1'b0;
    logic [10:0] rptr;
    logic [10:0] level;
    logic        empty;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ram [1024];
    logic [31:0] exp_q [$];
    logic [10:0] wp_w = '0;
    bit          sb_en = 1'b1;
    int          n_words = 0;
    int          n_en = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic        prev_flush = 1'b0;
    logic [31:0] prev_word = '0;

    system_buffer_reader dut (
        .clock           (clock),
        .resetn          (resetn),
        .Write_Pointer_I (wp),
        .Flush_I         (flush),
        .Enable_B_O      (en),
        .Address_B_O     (addr),
        .Data_B_I        (data_b),
        .Word_O          (word),
        .Word_Valid_O    (wvalid),
        .Word_Ready_I    (ready),
        .Read_Pointer_O  (rptr),
        .Level_O         (level),
        .Empty_O         (empty),
        .Overrun_O       (overrun)
    );

    always #5 clock = ~clock;

    // Buffer RAM port B: one-cycle read latency.
    always @(posedge clock) begin
        if (en) data_b <= ram[addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Writer model: store a word at the writer pointer and expect it in order.
    task automatic write_word(input logic [31:0] v);
        ram[wp_w[9:0]] = v;
        exp_q.push_back(v);
        wp_w = wp_w + 11'd1;
    endtask

    task automatic monitor();
        if (en) check_eq("enable_while_empty", {31'b0, empty}, 32'd0);
        if (en) n_en++;
        if (prev_valid && !prev_ready && !prev_flush) begin
            check_eq("hold_valid", {31'b0, wvalid}, 32'd1);
            check_eq("hold_word", word, prev_word);
        end
        if (flush) begin
            exp_q.delete();
        end else if (wvalid && ready) begin
            n_words++;
            if (sb_en) begin
                check_eq("word_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check_eq("word_order", word, exp_q.pop_front());
            end
        end
        prev_valid = wvalid;
        prev_ready = ready;
        prev_flush = flush;
        prev_word  = word;
    endtask

    task automatic drive(input logic r, input logic f);
        @(negedge clock);
        wp = wp_w;
        ready = r;
        flush = f;
        #1;
        monitor();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        wp_w = '0;
        wp = '0;
        ready = 1'b0;
        flush = 1'b0;
        #1;
        check_eq({tag, "_en"},      {31'b0, en}, 32'd0);
        check_eq({tag, "_addr"},    {22'b0, addr}, 32'd0);
        check_eq({tag, "_word"},    word, 32'd0);
        check_eq({tag, "_valid"},   {31'b0, wvalid}, 32'd0);
        check_eq({tag, "_rptr"},    {21'b0, rptr}, 32'd0);
        check_eq({tag, "_level"},   {21'b0, level}, 32'd0);
        check_eq({tag, "_empty"},   {31'b0, empty}, 32'd1);
        check_eq({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
        exp_q.delete();
        prev_valid = 1'b0;
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] abc [3];
        logic [31:0] first;
        int          w0;
        int          lvl;
        int          k;
        int          cyc;

        abc[0] = 32'hA0A0_0001;
        abc[1] = 32'hB0B0_0002;
        abc[2] = 32'hC0C0_0003;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        #7;
        resetn = 1'b1;

        // Three words, parser always ready.
        do_reset("reset1");
        for (int i = 0; i < 3; i++) write_word(abc[i]);
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0);
            check_eq("t1_en", {31'b0, en}, (c < 3) ? 32'd1 : 32'd0);
            if (c < 3) check_eq("t1_addr", {22'b0, addr}, c);
            check_eq("t1_valid", {31'b0, wvalid}, (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
            if (c >= 2 && c <= 4) check_eq("t1_word", word, abc[c-2]);
        end
        check_eq("t1_rptr", {21'b0, rptr}, 32'd3);
        check_eq("t1_empty", {31'b0, empty}, 32'd1);

        // Backpressure: only two reads issued, head held.
        do_reset("reset2");
        for (int i = 0; i < 8; i++) write_word($urandom);
        first = ram[0];
        n_en = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0);
            if (c >= 2) check_eq("t2_head", word, first);
        end
        check_eq("t2_reads", n_en, 32'd2);
        w0 = n_words;
        for (int c = 0; c < 8; c++) drive(1'b1, 1'b0);
        check_eq("t2_burst", n_words - w0, 32'd8);
        drive(1'b1, 1'b0);
        check_eq("t2_drained", exp_q.size(), 32'd0);

        // Random writer and parser over 5000 words.
        do_reset("reset3");
        w0 = n_words;
        cyc = 0;
        while ((n_words - w0) < 5000 && cyc < 40000) begin
            k = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 3);
            lvl = int'(11'(wp_w - rptr));
            if (lvl + k <= 1024) begin
                for (int i = 0; i < k; i++) write_word($urandom);
            end
            drive($urandom_range(0, 2) != 0 ? 1'b1 : 1'b0, 1'b0);
            cyc++;
        end
        check_eq("t3_done", {31'b0, (n_words - w0) >= 5000}, 32'd1);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            drive(1'b1, 1'b0);
            cyc++;
        end
        check_eq("t3_drained", exp_q.size(), 32'd0);
        check_eq("t3_no_overrun", {31'b0, overrun}, 32'd0);

        // Address wrap 0x3FE -> 0x001.
        do_reset("reset4");
        wp_w = 11'h3FE;
        drive(1'b1, 1'b1);
        check_eq("t4_flush_en", {31'b0, en}, 32'd0);
        for (int i = 0; i < 4; i++) write_word($urandom);
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0);
            check_eq("t4_en", {31'b0, en}, 32'd1);
            check_eq("t4_addr", {22'b0, addr}, (c < 2) ? (32'h3FE + c) : (c - 2));
        end
        drive(1'b1, 1'b0);
        check_eq("t4_rptr", {21'b0, rptr}, 32'h402);
        check_eq("t4_msb", {31'b0, rptr[10]}, 32'd1);
        for (int c = 0; c < 3; c++) drive(1'b1, 1'b0);
        check_eq("t4_drained", exp_q.size(), 32'd0);

        // Flush with data captured and a read in flight.
        do_reset("reset5");
        for (int i = 0; i < 8; i++) write_word($urandom);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        wp_w = 11'h050;
        drive(1'b0, 1'b1);
        check_eq("t5_flush_en", {31'b0, en}, 32'd0);
        drive(1'b1, 1'b0);
        check_eq("t5_valid", {31'b0, wvalid}, 32'd0);
        check_eq("t5_rptr", {21'b0, rptr}, 32'h050);
        check_eq("t5_empty", {31'b0, empty}, 32'd1);
        w0 = n_words;
        write_word($urandom);
        write_word($urandom);
        for (int c = 0; c < 6; c++) drive(1'b1, 1'b0);
        check_eq("t5_words", n_words - w0, 32'd2);
        check_eq("t5_drained", exp_q.size(), 32'd0);

        // Overrun: sticky until reset.
        do_reset("reset6");
        sb_en = 1'b0;
        wp_w = 11'h401;
        drive(1'b1, 1'b0);
        check_eq("t6_level", {21'b0, level}, 32'h401);
        check_eq("t6_overrun_pre", {31'b0, overrun}, 32'd0);
        drive(1'b1, 1'b0);
        check_eq("t6_overrun_set", {31'b0, overrun}, 32'd1);
        for (int c = 0; c < 10; c++) drive($urandom_range(0, 1) != 0 ? 1'b1 : 1'b0, 1'b0);
        check_eq("t6_overrun_sticky", {31'b0, overrun}, 32'd1);
        do_reset("reset7");
        sb_en = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
